hazard_ctrl: RTL and testbench

Pipeline hazard controller for the in-order RISC-V core. It sits beside the decode stage and keeps a 32-entry register scoreboard of in-flight writes. From that it stalls fetch/decode on read-after-write and write-after-write hazards, injects bubbles into the decode-to-execute register, and sequences the squash of younger instructions after an execute-stage redirect (branch/JAL/JALR).

---
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the in-order core.
// Tracks in-flight register writes in a 32-entry scoreboard and uses it to
// stall decode on RAW/WAW hazards. After an execute-stage redirect it squashes
// fetch/decode for FLUSH_CYCLES cycles. It also counts stalled cycles.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | normal issue; stall/bubble on scoreboard hazards
//   FLUSH | squashing younger instructions; fcnt counts remaining cycles
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             de_valid,
    input  logic [4:0]       de_rs1,
    input  logic [4:0]       de_rs2,
    input  logic             de_use_rs1,
    input  logic             de_use_rs2,
    input  logic [4:0]       de_rd,
    input  logic             de_reg_write,
    input  logic             wb_en,
    input  logic [4:0]       wb_rd,
    input  logic             ex_redirect,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic [31:0]      busy_map,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Reload value for the flush down-counter. The redirect cycle itself is the
    // first squash cycle, so the counter only covers the remaining cycles.
    localparam logic [3:0] FCNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  fcnt;
    logic [3:0]  fcnt_nxt;
    logic [31:0] busy_nxt;
    logic        raw;
    logic        waw;
    logic        issue;

    // Hazard detection from the registered scoreboard only. There is no
    // writeback bypass because the register file write and the decode read
    // happen on the same edge.
    always_comb begin
        raw = de_valid &
              ((de_use_rs1 & (de_rs1 != 5'd0) & busy_map[de_rs1]) |
               (de_use_rs2 & (de_rs2 != 5'd0) & busy_map[de_rs2]));
        waw = de_valid & de_reg_write & (de_rd != 5'd0) & busy_map[de_rd];
    end

    // Next-state logic and the combinational stall/bubble/flush outputs.
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        stall     = 1'b0;
        bubble    = 1'b0;
        flush     = 1'b0;
        issue     = 1'b0;

        if (ex_redirect) begin
            flush    = 1'b1;
            bubble   = 1'b1;
            fcnt_nxt = FCNT_LOAD;
            // With a single-cycle flush the redirect cycle covers everything.
            state_nxt = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
        end else begin
            case (state)
                RUN: begin
                    stall  = raw | waw;
                    bubble = raw | waw;
                    issue  = de_valid & ~(raw | waw);
                end
                FLUSH: begin
                    flush    = 1'b1;
                    bubble   = 1'b1;
                    fcnt_nxt = fcnt - 4'd1;
                    if (fcnt == 4'd1) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    fcnt_nxt  = 4'd0;
                end
            endcase
        end

        if (rst) begin
            stall  = 1'b0;
            bubble = 1'b0;
            flush  = 1'b0;
            issue  = 1'b0;
        end
    end

    // Scoreboard update. The issue set is applied after the writeback clear so
    // that a new writer of the same index keeps its busy bit. x0 is never tracked.
    always_comb begin
        busy_nxt = busy_map;
        if (wb_en && (wb_rd != 5'd0)) begin
            busy_nxt[wb_rd] = 1'b0;
        end
        if (issue && de_reg_write && (de_rd != 5'd0)) begin
            busy_nxt[de_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // State register, flush counter and scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            fcnt     <= 4'd0;
            busy_map <= 32'd0;
        end else begin
            state    <= state_nxt;
            fcnt     <= fcnt_nxt;
            busy_map <= busy_nxt;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios followed by random traffic,
// checked against a behavioural model of the scoreboard and flush window.
// Two instances run on the same stimulus: the default configuration and a
// single-cycle-flush, 3-bit-counter configuration that reaches saturation.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        de_valid;
    logic [4:0]  de_rs1;
    logic [4:0]  de_rs2;
    logic        de_use_rs1;
    logic        de_use_rs2;
    logic [4:0]  de_rd;
    logic        de_reg_write;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic        ex_redirect;

    logic [1:0]  stall_o;
    logic [1:0]  bubble_o;
    logic [1:0]  flush_o;
    logic [31:0] busy0;
    logic [31:0] busy1;
    logic [31:0] sc0;
    logic [2:0]  sc1;

    int n_vec;
    int n_err;

    // Model state per instance: busy bits, remaining squash cycles after the
    // current one, and the stall counter.
    logic [31:0] m_busy [2];
    int          m_left [2];
    longint      m_cnt  [2];
    int          m_fc   [2];
    longint      m_cmax [2];

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2), .de_rd(de_rd),
        .de_reg_write(de_reg_write), .wb_en(wb_en), .wb_rd(wb_rd),
        .ex_redirect(ex_redirect), .stall(stall_o[0]), .bubble(bubble_o[0]),
        .flush(flush_o[0]), .busy_map(busy0), .stall_count(sc0)
    );

    hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2), .de_rd(de_rd),
        .de_reg_write(de_reg_write), .wb_en(wb_en), .wb_rd(wb_rd),
        .ex_redirect(ex_redirect), .stall(stall_o[1]), .bubble(bubble_o[1]),
        .flush(flush_o[1]), .busy_map(busy1), .stall_count(sc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check every output against the model, then
    // advance the model to what the next clock edge should produce.
    task automatic cyc(input logic r, input logic dv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd, input logic rw,
                       input logic we, input logic [4:0] wrd, input logic redir);
        logic   in_fl, hz, e_st, e_bu, e_fl, iss;
        logic [31:0] obs_busy;
        longint obs_cnt;
        @(posedge clk);
        #1;
        rst = r; de_valid = dv; de_rs1 = rs1; de_rs2 = rs2; de_use_rs1 = u1; de_use_rs2 = u2;
        de_rd = rd; de_reg_write = rw; wb_en = we; wb_rd = wrd; ex_redirect = redir;
        #2;
        for (int i = 0; i < 2; i++) begin
            in_fl = redir || (m_left[i] > 0);
            hz = dv && ((u1 && rs1 != 0 && m_busy[i][rs1]) ||
                        (u2 && rs2 != 0 && m_busy[i][rs2]) ||
                        (rw && rd != 0 && m_busy[i][rd]));
            e_fl = !r && in_fl;
            e_st = !r && !in_fl && hz;
            e_bu = e_fl || e_st;
            iss  = !r && dv && !in_fl && !hz;
            obs_busy = (i == 0) ? busy0 : busy1;
            obs_cnt  = (i == 0) ? longint'(sc0) : longint'(sc1);
            chk($sformatf("stall%0d", i),  64'(stall_o[i]),  64'(e_st));
            chk($sformatf("bubble%0d", i), 64'(bubble_o[i]), 64'(e_bu));
            chk($sformatf("flush%0d", i),  64'(flush_o[i]),  64'(e_fl));
            chk($sformatf("busy%0d", i),   64'(obs_busy),    64'(m_busy[i]));
            chk($sformatf("count%0d", i),  64'(obs_cnt),     64'(m_cnt[i]));
            if (r) begin
                m_busy[i] = 32'd0;
                m_left[i] = 0;
                m_cnt[i]  = 0;
            end else begin
                if (we && wrd != 0) m_busy[i][wrd] = 1'b0;
                if (iss && rw && rd != 0) m_busy[i][rd] = 1'b1;
                if (redir) m_left[i] = m_fc[i] - 1;
                else if (m_left[i] > 0) m_left[i] = m_left[i] - 1;
                if (e_st && m_cnt[i] < m_cmax[i]) m_cnt[i] = m_cnt[i] + 1;
            end
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] base;
        n_vec = 0;
        n_err = 0;
        m_fc[0] = 2;  m_cmax[0] = 64'hFFFF_FFFF;
        m_fc[1] = 1;  m_cmax[1] = 7;
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 32'd0; m_left[i] = 0; m_cnt[i] = 0;
        end
        rst = 1'b1; de_valid = 0; de_rs1 = 0; de_rs2 = 0; de_use_rs1 = 0; de_use_rs2 = 0;
        de_rd = 0; de_reg_write = 0; wb_en = 0; wb_rd = 0; ex_redirect = 0;

        // Reset then idle.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_count", 64'(sc0), 64'd0);

        // RAW on x5: stall until writeback, drop the cycle after it.
        cyc(0, 1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
        base = sc0;
        cyc(0, 1, 5, 0, 1, 0, 6, 1, 0, 0, 0);
        chk("raw_stall", 64'(stall_o[0]), 64'd1);
        cyc(0, 1, 5, 0, 1, 0, 6, 1, 0, 0, 0);
        cyc(0, 1, 5, 0, 1, 0, 6, 1, 0, 0, 0);
        cyc(0, 1, 5, 0, 1, 0, 6, 1, 1, 5, 0);
        cyc(0, 1, 5, 0, 1, 0, 6, 1, 0, 0, 0);
        chk("raw_release", 64'(stall_o[0]), 64'd0);
        idle();
        chk("raw_count", 64'(sc0 - base), 64'd4);

        // Writes to x0 never mark the scoreboard.
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 1, 6, 0);
        cyc(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        chk("x0_busy", 64'(busy0), 64'd0);

        // Same-cycle issue and writeback of x7: set wins, then WAW stall.
        cyc(0, 1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
        idle();
        chk("set_wins", 64'(busy0[7]), 64'd1);
        cyc(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        chk("waw_stall", 64'(stall_o[0]), 64'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);

        // Redirect window, extended by a second redirect; busy bits retained.
        cyc(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 8, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 8, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0);
        chk("flush_ext", 64'(flush_o[0]), 64'd1);
        cyc(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
        chk("flush_done", 64'(flush_o[0]), 64'd0);
        idle();
        chk("busy_kept", 64'({busy0[3], busy0[4], busy0[8]}), 64'b110);

        // Reset in the middle of a flush window.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("rst_flush_busy", 64'(busy0), 64'd0);
        chk("rst_flush_out", 64'({stall_o[0], flush_o[0]}), 64'd0);

        // Random traffic on a small register window to provoke hazards.
        for (int n = 0; n < 1500; n++) begin
            cyc(1'($urandom_range(0, 99) == 0),
                1'($urandom_range(0, 3) != 0),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 11) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
